// File: rtl/uart_rx_fifo.sv
// Receive FIFO for a UART receiver: buffers {err, data} packets and tracks overflow and errors.
// Latency: a packet written into an empty FIFO is visible on rd_* the cycle after its in_valid edge.
// Backpressure: none toward the receiver; packets arriving while full without a pop are dropped.
//
// Ports:
//   r_clk, r_rst          receive-domain clock, asynchronous active-high reset
//   in_valid/in_data/in_err  one-cycle packet strobe from the receiver
//   rd_valid/rd_ready/rd_data/rd_err  show-ahead read side (head entry presented combinationally)
//   level/full/empty      occupancy
//   overflow, err_cnt, clr_status  sticky drop flag, saturating error count, and their clear pulse
module uart_rx_fifo #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 16,
    parameter bit DROP_ERR    = 1'b0
) (
    input  logic                       r_clk,
    input  logic                       r_rst,
    input  logic                       in_valid,
    input  logic [WORD_LENGTH-1:0]     in_data,
    input  logic                       in_err,
    input  logic                       rd_ready,
    input  logic                       clr_status,
    output logic                       rd_valid,
    output logic [WORD_LENGTH-1:0]     rd_data,
    output logic                       rd_err,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [7:0]                 err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WORD_LENGTH:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;

    logic pop;
    logic wr;
    logic filtered;
    logic drop;
    logic err_strobe;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LVL);
    assign rd_valid = ~empty;

    // Show-ahead: head entry read straight from the array.
    assign rd_err  = mem[rd_ptr][WORD_LENGTH];
    assign rd_data = mem[rd_ptr][WORD_LENGTH-1:0];

    assign err_strobe = in_valid & in_err;
    assign filtered   = DROP_ERR & in_err;
    assign pop        = rd_valid & rd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign wr         = in_valid & ~filtered & (~full | pop);
    // Filtered packets are discarded by choice, not for lack of room.
    assign drop       = in_valid & ~filtered & full & ~pop;

    // The array is reset so rd_data reads 0 (never X) until something is written.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr) begin
            mem[wr_ptr] <= {in_err, in_data};
        end
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // A new drop or error in the clearing cycle wins over the clear.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            overflow <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end

            if (clr_status) begin
                err_cnt <= err_strobe ? 8'd1 : 8'd0;
            end else if (err_strobe && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_err = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clr_status = 1'b0;

    logic       rd_valid, rd_err, full, empty, overflow;
    logic [7:0] rd_data, err_cnt;
    logic [4:0] level;

    logic       d1_rd_valid, d1_rd_err, d1_full, d1_empty, d1_overflow;
    logic [7:0] d1_rd_data, d1_err_cnt;
    logic [4:0] d1_level;

    always #5 r_clk = ~r_clk;

    uart_rx_fifo #(.WORD_LENGTH(8), .DEPTH(DEPTH), .DROP_ERR(1'b0)) dut (
        .r_clk(r_clk), .r_rst(r_rst), .in_valid(in_valid), .in_data(in_data),
        .in_err(in_err), .rd_ready(rd_ready), .clr_status(clr_status),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .level(level),
        .full(full), .empty(empty), .overflow(overflow), .err_cnt(err_cnt)
    );

    uart_rx_fifo #(.WORD_LENGTH(8), .DEPTH(DEPTH), .DROP_ERR(1'b1)) dut_drop (
        .r_clk(r_clk), .r_rst(r_rst), .in_valid(in_valid), .in_data(in_data),
        .in_err(in_err), .rd_ready(rd_ready), .clr_status(clr_status),
        .rd_valid(d1_rd_valid), .rd_data(d1_rd_data), .rd_err(d1_rd_err), .level(d1_level),
        .full(d1_full), .empty(d1_empty), .overflow(d1_overflow), .err_cnt(d1_err_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model of the DROP_ERR=0 instance.
    logic [8:0] q[$];
    logic       m_ovf;
    logic [7:0] m_cnt;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e;
        logic       rdy;
        logic       clr;
        logic [4:0] exp_level;
        logic       exp_ovf;
        logic [7:0] exp_cnt;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_cnt = 8'd0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic e,
                        input logic rdy, input logic clr);
        logic       wr;
        logic [8:0] head;
        @(negedge r_clk);
        in_valid = v; in_data = d; in_err = e; rd_ready = rdy; clr_status = clr;
        #1;
        if (rdy && q.size() > 0) begin
            head = q.pop_front();
            chk("pop_data", rd_data, head[7:0]);
            chk("pop_err", rd_err, head[8]);
        end
        wr = v && (q.size() < DEPTH);
        if (wr) q.push_back({e, d});
        if (v && !wr) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_cnt = (v && e) ? 8'd1 : 8'd0;
        else if (v && e && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        @(posedge r_clk);
        #1;
        in_valid = 1'b0; rd_ready = 1'b0; clr_status = 1'b0; in_err = 1'b0;
        chk("level", level, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("rd_valid", rd_valid, q.size() > 0);
        chk("overflow", overflow, m_ovf);
        chk("err_cnt", err_cnt, m_cnt);
        if (q.size() > 0) begin
            chk("head_data", rd_data, q[0][7:0]);
            chk("head_err", rd_err, q[0][8]);
        end
    endtask

    task automatic do_reset();
        @(negedge r_clk);
        r_rst = 1'b1;
        model_reset();
        @(negedge r_clk);
        r_rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (q.size() > 0) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 8'd1};
        vecs[3]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 8'd2};
        vecs[4]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 8'd3};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd1};
        vecs[9]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd1};

        model_reset();
        #1;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_rd_data", rd_data, 0);
        do_reset();
        #1;
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // Single packet, error path, clr collisions, pop on empty.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
            chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
            chk($sformatf("vec%0d_cnt", i), err_cnt, vecs[i].exp_cnt);
        end

        // Fill and overflow, then drain in order.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_ovf", overflow, 1);
        chk("fill_level", level, 16);
        drain();
        chk("drain_empty", empty, 1);

        // Full: clear colliding with a drop keeps overflow; then write+pop while full.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("clr_drop_ovf", overflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", overflow, 0);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        chk("full_wp_level", level, 16);
        chk("full_wp_ovf", overflow, 0);
        drain();

        // Error packets: stored with rd_err in one instance, filtered in the other.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b1, 1'b0, 1'b0);
        chk("err3_cnt", err_cnt, 3);
        chk("drop_cnt", d1_err_cnt, 3);
        chk("drop_level", d1_level, 0);
        chk("drop_empty", d1_empty, 1);
        chk("drop_rd_valid", d1_rd_valid, 0);
        chk("drop_full", d1_full, 0);
        chk("drop_ovf", d1_overflow, 0);
        chk("drop_rd_data", d1_rd_data, 0);
        chk("drop_rd_err", d1_rd_err, 0);
        drain();
        for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
        chk("sat_cnt", err_cnt, 255);
        chk("sat_cnt_drop", d1_err_cnt, 255);
        drain();

        // Asynchronous reset mid-cycle with five entries held.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), (i == 2), 1'b0, 1'b0);
        @(negedge r_clk);
        #2;
        r_rst = 1'b1;
        #1;
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_cnt", err_cnt, 0);
        chk("arst_rd_data", rd_data, 0);
        chk("arst_rd_err", rd_err, 0);
        model_reset();
        @(negedge r_clk);
        r_rst = 1'b0;
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("post_rst_level", level, 1);

        // Pointer wrap over 40 writes with interleaved pops.
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), i[0], (i % 3 != 0), 1'b0);
        drain();
        chk("wrap_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter WORD_LENGTH, default 8, data bits per received packet; matches the receiver's word length.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, minimum 2.
REQ-003 Parameter DROP_ERR, default 0; 1 = packets flagged in error are counted but not stored.
REQ-004 r_clk  input  1  receive-domain clock; all state updates on rising edge.
REQ-005 r_rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  one-cycle strobe, a received packet is present on in_data/in_err.
REQ-007 in_data  input  WORD_LENGTH  received packet payload.
REQ-008 in_err  input  1  1 = packet failed parity/stop check.
REQ-009 rd_ready  input  1  consumer accepts the head entry this cycle.
REQ-010 clr_status  input  1  one-cycle pulse, clears overflow and err_cnt.
REQ-011 rd_valid  output  1  head entry available (FIFO not empty).
REQ-012 rd_data  output  WORD_LENGTH  head entry payload, valid while rd_valid=1.
REQ-013 rd_err  output  1  head entry error flag, valid while rd_valid=1.
REQ-014 level  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-015 full  output  1  level==DEPTH.
REQ-016 empty  output  1  level==0.
REQ-017 overflow  output  1  sticky, a packet was dropped because the FIFO was full.
REQ-018 err_cnt  output  8  saturating count of in_valid strobes with in_err=1.

Function
REQ-019 Storage: DEPTH entries of {in_err, in_data}; binary write/read pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-020 Write: accepted on a clock edge with in_valid=1 and not full, excluding DROP_ERR=1 with in_err=1; entry stored at the write pointer, which then increments.
REQ-021 Pop: occurs on a clock edge with rd_valid=1 and rd_ready=1; the read pointer increments; rd_ready while empty is ignored.
REQ-022 Show-ahead: rd_data/rd_err reflect the head entry combinationally from the read pointer; rd_valid = ~empty.
REQ-023 Latency: a packet written into an empty FIFO appears with rd_valid=1 in the cycle after the in_valid edge.
REQ-024 Simultaneous write and pop when not full and not empty: both occur, level unchanged.
REQ-025 Simultaneous write and pop when empty: the write occurs, the pop is ignored, level becomes 1.
REQ-026 Full plus in_valid with rd_ready=1 and rd_valid=1 the same cycle: the pop frees a slot, the write is accepted, level stays DEPTH, overflow unchanged.
REQ-027 Full plus in_valid without a pop: the packet is dropped, overflow is set to 1, and stored data and pointers are unchanged.
REQ-028 Overflow: stays 1 until clr_status or reset; if clr_status coincides with a new drop, overflow ends at 1.
REQ-029 err_cnt: increments on every in_valid with in_err=1, whether the packet is stored, dropped or filtered; holds at 255.
REQ-030 clr_status: sets err_cnt to 0; if clr_status coincides with a counted error, err_cnt ends at 1.
REQ-031 Level: updates in the same edge as the write/pop; full/empty derive combinationally from level.
REQ-032 Outputs: no X on any output after reset, including rd_data while empty, which holds the last addressed entry or 0.

Reset
REQ-033 Asynchronous r_rst assertion immediately forces: pointers=0, level=0, empty=1, full=0, rd_valid=0, overflow=0, err_cnt=0; rd_data=0 and rd_err=0.
REQ-034 Reset mid-operation discards all stored entries; no pop or write completes on the edge coincident with reset.
REQ-035 After deassertion the first in_valid is accepted on the next rising edge.

Verification
REQ-036 Single packet: in_valid, data 0xA5, err 0, into empty FIFO -> next cycle rd_valid=1, rd_data=0xA5, rd_err=0, level=1; pop with rd_ready -> empty=1.
REQ-037 Fill/overflow (DEPTH=16): write 0x00..0x0F then 0x10 with no pops -> full=1, overflow=1, level=16; drain yields 0x00..0x0F in order, 0x10 absent.
REQ-038 Full with simultaneous write and pop: 0x55 written while popping head -> level stays 16, overflow=0, 0x55 emerges last.
REQ-039 Error path: DROP_ERR=0, 3 packets with in_err=1 -> err_cnt=3, entries stored with rd_err=1; DROP_ERR=1 -> err_cnt=3, level=0; 300 errors -> err_cnt=255.
REQ-040 clr_status coincident with an error strobe -> err_cnt=1; coincident with an overflow drop -> overflow=1.
REQ-041 Reset with 5 entries stored, asynchronous mid-cycle -> outputs at reset values before the next edge; pointer wrap after 40 writes/pops stays in order.
